latch_bank_ctrl: RTL

- Write controller and round-robin arbiter for a bank of 2**AW level-sensitive D latches, each DW bits wide.
- Shares the bank between NREQ requesters and sequences every write as setup, gate-open, then hold, so latch data is stable around the gate edges.
- Also services a bank-wide clear request, which has priority over writes.
- Sits between requester logic and the latch bank; it drives the bank's d, gate-enable and clear lines.

---
 rtl/latch_ctrl_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/latch_bank_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and sizing helpers for the latch bank write controller.
// Holds the FSM state encoding, the default bank size and the counter-width helper.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETUP,
    OPEN,
    HOLD
  } state_e;

  localparam int DEF_AW = 2;

  function automatic int lat_count(input int aw);
    return 1 << aw;
  endfunction

  localparam int NLAT = lat_count(DEF_AW);

  // Wide enough to hold the value open_cyc itself, since the gate counter loads it directly.
  function automatic int cnt_width(input int open_cyc);
    return (open_cyc < 1) ? 1 : $clog2(open_cyc + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first unmasked requester
// found when searching upward from ptr_i with wrap-around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winner_o
);

  logic [NREQ-1:0] eligible;
  logic            found;

  assign eligible = req_i & ~mask_i;

  // Outer loop walks the search distance from ptr, inner loop finds the index at that distance.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == ((int'(ptr_i) + i) % NREQ)) && eligible[j]) begin
          winner_o[j] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller and round-robin arbiter for a bank of level-sensitive latches.
// Each write runs SETUP -> OPEN (gate high) -> HOLD so data is stable around both gate edges.
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int AW       = DEF_AW,
  parameter int OPEN_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*AW-1:0]   waddr_i,
  input  logic [NREQ*DW-1:0]   wdata_i,
  input  logic                 clr_req_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      ack_o,
  output logic                 clr_ack_o,
  output logic [DW-1:0]        lat_d_o,
  output logic [(1<<AW)-1:0]   lat_en_o,
  output logic                 lat_clr_o,
  output logic                 busy_o
);

  localparam int NL = (AW == DEF_AW) ? NLAT : lat_count(AW);
  localparam int PW = $clog2(NREQ);
  localparam int CW = cnt_width(OPEN_CYC);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            clr_ack_q;
  logic            lat_clr_q;
  logic [DW-1:0]   lat_d_q;
  logic [AW-1:0]   addr_q;
  logic [NL-1:0]   lat_en_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_idx_q;

  logic [NREQ-1:0] arb_mask;
  logic [PW-1:0]   arb_ptr;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] gnt_d;
  logic [DW-1:0]   data_d;
  logic [AW-1:0]   addr_d;
  logic [PW-1:0]   idx_d;
  logic [NL-1:0]   en_dec;

  assign next_ptr = (win_idx_q == PW'(NREQ - 1)) ? '0 : win_idx_q + PW'(1);

  // In HOLD the current winner is masked and the search starts just past it.
  assign arb_mask = (state_q == HOLD) ? gnt_q : '0;
  assign arb_ptr  = (state_q == HOLD) ? next_ptr : ptr_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i    (req_i),
    .mask_i   (arb_mask),
    .ptr_i    (arb_ptr),
    .winner_o (gnt_d)
  );

  always_comb begin
    data_d = '0;
    addr_d = '0;
    idx_d  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_d[j]) begin
        data_d = wdata_i[j*DW +: DW];
        addr_d = waddr_i[j*AW +: AW];
        idx_d  = PW'(j);
      end
    end
  end

  always_comb begin
    en_dec = '0;
    for (int k = 0; k < NL; k++) begin
      en_dec[k] = (addr_q == AW'(k));
    end
  end

  // Single FSM register block; every bank-facing output is a flop so the latch gates never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      clr_ack_q <= 1'b0;
      lat_clr_q <= 1'b0;
      lat_d_q   <= '0;
      addr_q    <= '0;
      lat_en_q  <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q   <= CLEAR;
            lat_clr_q <= 1'b1;
            clr_ack_q <= 1'b1;
          end else if (|gnt_d) begin
            state_q   <= SETUP;
            gnt_q     <= gnt_d;
            lat_d_q   <= data_d;
            addr_q    <= addr_d;
            win_idx_q <= idx_d;
          end
        end
        CLEAR: begin
          lat_clr_q <= 1'b0;
          clr_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
        SETUP: begin
          lat_en_q <= en_dec;
          cnt_q    <= CW'(OPEN_CYC);
          state_q  <= OPEN;
        end
        OPEN: begin
          if (cnt_q == CW'(1)) begin
            lat_en_q <= '0;
            ack_q    <= gnt_q;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          ack_q <= '0;
          gnt_q <= '0;
          ptr_q <= next_ptr;
          if (clr_req_i) begin
            state_q   <= CLEAR;
            lat_clr_q <= 1'b1;
            clr_ack_q <= 1'b1;
          end else if (|gnt_d) begin
            state_q   <= SETUP;
            gnt_q     <= gnt_d;
            lat_d_q   <= data_d;
            addr_q    <= addr_d;
            win_idx_q <= idx_d;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign ack_o     = ack_q;
  assign clr_ack_o = clr_ack_q;
  assign lat_clr_o = lat_clr_q;
  assign lat_d_o   = lat_d_q;
  assign lat_en_o  = lat_en_q;
  assign busy_o    = (state_q != IDLE);

endmodule
